// File: rtl/shared_adder_sched.sv
// Round-robin scheduler sharing one WIDTH-bit adder among three requesters.
// Each accepted operand pair is added and returned tagged with its channel id.
module shared_adder_sched #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           req_valid,
    output logic [2:0]           req_ready,
    input  logic [3*WIDTH-1:0]   req_a,
    input  logic [3*WIDTH-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [WIDTH:0]       rsp_sum,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              last_grant;
    logic [1:0]              cand0;
    logic [1:0]              cand1;
    logic [1:0]              cand2;
    logic                    grant_any;
    logic [1:0]              grant_id;
    logic [2:0]              grant_oh;
    logic                    accept;
    logic [WIDTH-1:0]        a_p0;
    logic [WIDTH-1:0]        b_p0;
    logic [1:0]              id_p0;
    logic [WIDTH:0]          sum_p1;

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    function automatic logic [WIDTH-1:0] lane(input logic [3*WIDTH-1:0] vec,
                                              input logic [1:0]         id);
        logic [WIDTH-1:0] r;
        case (id)
            2'd1:    r = vec[WIDTH +: WIDTH];
            2'd2:    r = vec[2*WIDTH +: WIDTH];
            default: r = vec[0 +: WIDTH];
        endcase
        return r;
    endfunction

    // Carry lands in the extra MSB, so the result never wraps or saturates.
    function automatic logic [WIDTH:0] add_wide(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Search starts one past the last winner and walks the ring once.
    always_comb begin
        cand0     = next_ch(last_grant);
        cand1     = next_ch(cand0);
        cand2     = next_ch(cand1);
        grant_any = 1'b0;
        grant_id  = 2'd0;
        if (req_valid[cand0]) begin
            grant_any = 1'b1;
            grant_id  = cand0;
        end else if (req_valid[cand1]) begin
            grant_any = 1'b1;
            grant_id  = cand1;
        end else if (req_valid[cand2]) begin
            grant_any = 1'b1;
            grant_id  = cand2;
        end
        grant_oh = grant_any ? (3'b001 << grant_id) : 3'b000;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 3'b000;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any && !reset) begin
                    req_ready = grant_oh;
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_p0;
    assign rsp_sum   = sum_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            last_grant <= 2'd2;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            if (accept) last_grant <= grant_id;
        end
    end

    // p0: operands and channel id captured at the request handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_p0  <= '0;
            b_p0  <= '0;
            id_p0 <= 2'd0;
        end else if (accept) begin
            a_p0  <= lane(req_a, grant_id);
            b_p0  <= lane(req_b, grant_id);
            id_p0 <= grant_id;
        end
    end

    // p1: shared adder result, held stable through the response phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_p1 <= '0;
        end else if (state == EXEC) begin
            sum_p1 <= add_wide(a_p0, b_p0);
        end
    end

endmodule
